// File: rtl/spi_master_mode.sv
// SPI master with selectable CPOL/CPHA and bit order. It generates SCLK from clk, drives cs_n,
// and shifts DATA_W bits full-duplex per transfer using a start/ready/done handshake.
module spi_master_mode #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned HALF_DIV  = 2,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DATA_W-1:0] tx_data,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n,
   output logic              spi_l,
   output logic              spi_t
);
   localparam int unsigned      DIV_W    = $clog2(HALF_DIV) + 1;
   localparam int unsigned      EC_W     = $clog2(2 * DATA_W) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [EC_W-1:0]  EC_INIT  = EC_W'(2 * DATA_W);
   localparam logic [EC_W-1:0]  EC_ONE   = EC_W'(1);

   typedef enum logic [1:0] {IDLE, LEAD, XFER, HOLD} state_t;

   state_t              state, state_next;
   logic [DIV_W-1:0]    div;
   logic [EC_W-1:0]     edge_cnt;
   logic                cpha_q;
   logic [DATA_W-1:0]   tx_sr, rx_sr;
   logic                accept, div_end, toggle, last_edge, finish, lead_edge, trail_edge;
   logic                tx_first, tx_bit;
   logic [DATA_W-1:0]   tx_first_rest, tx_rest, rx_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      toggle     = 1'b0;
      last_edge  = 1'b0;
      finish     = 1'b0;
      div_end    = (div == DIV_LAST);
      case (state)
         IDLE: if (start) begin
            accept     = 1'b1;
            state_next = LEAD;
         end
         LEAD: if (div_end) state_next = XFER;
         XFER: if (div_end) begin
            toggle = 1'b1;
            if (edge_cnt == EC_ONE) begin
               last_edge  = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: if (div_end) begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // edge_cnt is even before every leading toggle (2W, 2W-2, ...)
      lead_edge  = toggle & ~edge_cnt[0];
      trail_edge = toggle & edge_cnt[0];
   end

   always_comb begin
      tx_first      = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
      tx_first_rest = MSB_FIRST ? (tx_data << 1) : (tx_data >> 1);
      tx_bit        = MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0];
      tx_rest       = MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
      rx_next       = MSB_FIRST ? {rx_sr[DATA_W-2:0], miso} : {miso, rx_sr[DATA_W-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready    <= 1'b1;
         done     <= 1'b0;
         rx_data  <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
         spi_l    <= 1'b0;
         spi_t    <= 1'b0;
         div      <= '0;
         edge_cnt <= '0;
         cpha_q   <= 1'b0;
         tx_sr    <= '0;
         rx_sr    <= '0;
      end else begin
         done  <= finish;
         spi_l <= lead_edge;
         spi_t <= trail_edge;
         ready <= (state_next == IDLE);
         cs_n  <= (state_next == IDLE);

         if (state == IDLE || div_end) div <= '0;
         else                          div <= div + DIV_ONE;

         if (state == IDLE) sclk <= cpol;

         if (accept) begin
            cpha_q   <= cpha;
            edge_cnt <= EC_INIT;
            rx_sr    <= '0;
            if (!cpha) begin
               mosi  <= tx_first;
               tx_sr <= tx_first_rest;
            end else begin
               tx_sr <= tx_data;
            end
         end

         if (toggle) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt - EC_ONE;
         end

         if (lead_edge) begin
            if (cpha_q) begin
               mosi  <= tx_bit;
               tx_sr <= tx_rest;
            end else begin
               rx_sr <= rx_next;
            end
         end

         if (trail_edge) begin
            if (cpha_q) begin
               rx_sr <= rx_next;
            end else if (!last_edge) begin
               mosi  <= tx_bit;
               tx_sr <= tx_rest;
            end
         end

         if (finish) rx_data <= rx_sr;
      end
   end
endmodule

// File: tb/tb_spi_master_mode.sv
// Directed bench for spi_master_mode: three builds (8b/H2/MSB, 8b/H2/LSB, 16b/H1/MSB)
// share one stimulus bus; sel chooses which instance is started and observed.
module tb_spi_master_mode;
   logic        clk = 1'b0;
   logic        rst_n, start, cpol, cpha, loop, slave_bit, miso;
   logic [15:0] tx;
   int          sel;
   int          n_asrt = 0;
   int          n_fail = 0;

   logic        start0, start1, start2;
   logic        ready0, done0, sclk0, mosi0, cs0, l0, t0;
   logic        ready1, done1, sclk1, mosi1, cs1, l1, t1;
   logic        ready2, done2, sclk2, mosi2, cs2, l2, t2;
   logic [7:0]  rx0, rx1;
   logic [15:0] rx2;
   logic        g_ready, g_done, g_sclk, g_mosi, g_cs_n, g_l, g_t;
   logic [15:0] g_rx;

   always #5 clk = ~clk;

   spi_master_mode #(.DATA_W(8), .HALF_DIV(2), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .start(start0), .cpol(cpol), .cpha(cpha), .tx_data(tx[7:0]),
      .ready(ready0), .done(done0), .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .miso(miso),
      .cs_n(cs0), .spi_l(l0), .spi_t(t0));

   spi_master_mode #(.DATA_W(8), .HALF_DIV(2), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .start(start1), .cpol(cpol), .cpha(cpha), .tx_data(tx[7:0]),
      .ready(ready1), .done(done1), .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .miso(miso),
      .cs_n(cs1), .spi_l(l1), .spi_t(t1));

   spi_master_mode #(.DATA_W(16), .HALF_DIV(1), .MSB_FIRST(1'b1)) u_wide (
      .clk(clk), .rst_n(rst_n), .start(start2), .cpol(cpol), .cpha(cpha), .tx_data(tx),
      .ready(ready2), .done(done2), .rx_data(rx2), .sclk(sclk2), .mosi(mosi2), .miso(miso),
      .cs_n(cs2), .spi_l(l2), .spi_t(t2));

   always_comb begin
      start0 = start && (sel == 0);
      start1 = start && (sel == 1);
      start2 = start && (sel == 2);
      case (sel)
         1: begin
            g_ready = ready1; g_done = done1; g_sclk = sclk1; g_mosi = mosi1;
            g_cs_n = cs1; g_l = l1; g_t = t1; g_rx = {8'h00, rx1};
         end
         2: begin
            g_ready = ready2; g_done = done2; g_sclk = sclk2; g_mosi = mosi2;
            g_cs_n = cs2; g_l = l2; g_t = t2; g_rx = rx2;
         end
         default: begin
            g_ready = ready0; g_done = done0; g_sclk = sclk0; g_mosi = mosi0;
            g_cs_n = cs0; g_l = l0; g_t = t0; g_rx = {8'h00, rx0};
         end
      endcase
      miso = loop ? g_mosi : slave_bit;
   end

   // One transfer from E0 until done (or budget). seq[i] is mosi seen after the i-th leading edge.
   task automatic run_xfer(input int s, input logic pol, input logic pha, input logic [15:0] txw,
                           input logic lp, input logic [7:0] sw,
                           output int n_done, output int tog, output int nl, output int nt,
                           output int max_gap, output logic [15:0] seq, output logic cs_ok);
      int   n, last_tog;
      logic prev;
      sel = s; cpol = pol; cpha = pha; tx = txw; loop = lp; slave_bit = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; tog = 0; nl = 0; nt = 0; max_gap = 0; last_tog = -1; seq = '0; cs_ok = 1'b1;
      prev = g_sclk;
      while (!g_done && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (g_sclk !== prev) begin
            tog++;
            if (last_tog >= 0 && (n - last_tog) > max_gap) max_gap = n - last_tog;
            last_tog = n;
         end
         prev = g_sclk;
         if (g_l) begin
            if (nl < 16) seq[nl] = g_mosi;
            if (!lp && nl < 8) slave_bit = sw[7 - nl];
            nl++;
         end
         if (g_t) nt++;
         if (!g_done && g_cs_n) cs_ok = 1'b0;
      end
      n_done = g_done ? n : -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; tx = '0; loop = 1'b0;
      slave_bit = 1'b0; sel = 0;
      repeat (3) @(posedge clk);
      #1;
      n_asrt++; if (g_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", g_ready); end
      n_asrt++; if (g_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", g_done); end
      n_asrt++; if (g_rx !== 16'h0) begin n_fail++; $display("FAIL reset_rx: got %h expected 0", g_rx); end
      n_asrt++; if (g_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", g_sclk); end
      n_asrt++; if (g_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", g_mosi); end
      n_asrt++; if (g_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", g_cs_n); end
      n_asrt++; if ({g_l, g_t} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {g_l, g_t}); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mode0;
      int nd, tg, nl, nt, mg; logic [15:0] seq; logic ok;
      run_xfer(0, 1'b0, 1'b0, 16'h00A5, 1'b1, 8'h00, nd, tg, nl, nt, mg, seq, ok);
      n_asrt++; if (nd != 36) begin n_fail++; $display("FAIL m0_done_edge: got %0d expected 36", nd); end
      n_asrt++; if (tg != 16) begin n_fail++; $display("FAIL m0_toggles: got %0d expected 16", tg); end
      n_asrt++; if (mg != 2) begin n_fail++; $display("FAIL m0_toggle_gap: got %0d expected 2", mg); end
      n_asrt++; if (g_rx !== 16'h00A5) begin n_fail++; $display("FAIL m0_rx: got %h expected 00a5", g_rx); end
      n_asrt++; if (seq[7:0] !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi_seq: got %h expected a5", seq[7:0]); end
      n_asrt++; if (!ok) begin n_fail++; $display("FAIL m0_cs_low: got cs_n high mid-transfer expected low"); end
      n_asrt++; if ({g_ready, g_cs_n, g_sclk} !== 3'b110) begin n_fail++; $display("FAIL m0_end_state: got %b expected 110", {g_ready, g_cs_n, g_sclk}); end
      @(posedge clk); #1;
      n_asrt++; if (g_done !== 1'b0) begin n_fail++; $display("FAIL m0_done_width: got %b expected 0", g_done); end
      run_xfer(0, 1'b0, 1'b0, 16'h0012, 1'b1, 8'h00, nd, tg, nl, nt, mg, seq, ok);
      n_asrt++; if (seq[7:0] !== 8'h48) begin n_fail++; $display("FAIL m0_order_seq: got %h expected 48", seq[7:0]); end
      n_asrt++; if (g_rx !== 16'h0012) begin n_fail++; $display("FAIL m0_order_rx: got %h expected 0012", g_rx); end
   endtask

   task automatic test_mode3;
      int nd, tg, nl, nt, mg; logic [15:0] seq; logic ok;
      run_xfer(0, 1'b1, 1'b1, 16'h003C, 1'b0, 8'hC3, nd, tg, nl, nt, mg, seq, ok);
      n_asrt++; if (nd != 36) begin n_fail++; $display("FAIL m3_done_edge: got %0d expected 36", nd); end
      n_asrt++; if (g_rx !== 16'h00C3) begin n_fail++; $display("FAIL m3_rx: got %h expected 00c3", g_rx); end
      n_asrt++; if (seq[7:0] !== 8'h3C) begin n_fail++; $display("FAIL m3_mosi_seq: got %h expected 3c", seq[7:0]); end
      n_asrt++; if (g_sclk !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_end: got %b expected 1", g_sclk); end
      repeat (3) @(posedge clk);
      #1;
      n_asrt++; if (g_sclk !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_idle: got %b expected 1", g_sclk); end
   endtask

   task automatic test_lsb_first;
      int nd, tg, nl, nt, mg; logic [15:0] seq; logic ok;
      run_xfer(1, 1'b0, 1'b1, 16'h0081, 1'b1, 8'h00, nd, tg, nl, nt, mg, seq, ok);
      n_asrt++; if (seq[7:0] !== 8'h81) begin n_fail++; $display("FAIL m1_lsb_seq: got %h expected 81", seq[7:0]); end
      n_asrt++; if (nl != 8 || nt != 8) begin n_fail++; $display("FAIL m1_strobes: got l=%0d t=%0d expected 8/8", nl, nt); end
      n_asrt++; if (g_rx !== 16'h0081) begin n_fail++; $display("FAIL m1_lsb_rx: got %h expected 0081", g_rx); end
      run_xfer(1, 1'b1, 1'b0, 16'h0081, 1'b1, 8'h00, nd, tg, nl, nt, mg, seq, ok);
      n_asrt++; if (seq[7:0] !== 8'h81) begin n_fail++; $display("FAIL m2_lsb_seq: got %h expected 81", seq[7:0]); end
      n_asrt++; if (nl != 8 || nt != 8) begin n_fail++; $display("FAIL m2_strobes: got l=%0d t=%0d expected 8/8", nl, nt); end
      n_asrt++; if (g_sclk !== 1'b1) begin n_fail++; $display("FAIL m2_sclk_end: got %b expected 1", g_sclk); end
      run_xfer(1, 1'b1, 1'b0, 16'h000D, 1'b1, 8'h00, nd, tg, nl, nt, mg, seq, ok);
      n_asrt++; if (seq[7:0] !== 8'h0D) begin n_fail++; $display("FAIL m2_order_seq: got %h expected 0d", seq[7:0]); end
      n_asrt++; if (g_rx !== 16'h000D) begin n_fail++; $display("FAIL m2_order_rx: got %h expected 000d", g_rx); end
   endtask

   task automatic test_back_to_back;
      int n, dones, nd;
      logic [15:0] rx_first;
      sel = 0; cpol = 1'b0; cpha = 1'b0; tx = 16'h005A; loop = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; n = 0; dones = 0; nd = -1; rx_first = '0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 9)  start = 1'b1;
         if (n == 10) start = 1'b0;
         if (n == 12) begin tx = 16'h00FF; cpha = 1'b1; end
         if (n == 30) begin tx = 16'h0066; cpha = 1'b0; start = 1'b1; end
         if (g_done) begin
            dones++;
            if (nd < 0) begin nd = n; rx_first = g_rx; end
         end
         if (n == 37) begin
            n_asrt++; if ({g_cs_n, g_ready} !== 2'b00) begin n_fail++; $display("FAIL b2b_restart: got cs_n/ready=%b expected 00", {g_cs_n, g_ready}); end
            start = 1'b0;
         end
      end
      n_asrt++; if (dones != 1) begin n_fail++; $display("FAIL b2b_single_done: got %0d expected 1", dones); end
      n_asrt++; if (nd != 36) begin n_fail++; $display("FAIL b2b_done_edge: got %0d expected 36", nd); end
      n_asrt++; if (rx_first !== 16'h005A) begin n_fail++; $display("FAIL b2b_rx1: got %h expected 005a", rx_first); end
      while (!g_done && n < 120) begin
         @(posedge clk); #1;
         n++;
      end
      n_asrt++; if (n != 73 || !g_done) begin n_fail++; $display("FAIL b2b_done2_edge: got %0d expected 73", n); end
      n_asrt++; if (g_rx !== 16'h0066) begin n_fail++; $display("FAIL b2b_rx2: got %h expected 0066", g_rx); end
   endtask

   task automatic test_reset_mid;
      int dones;
      sel = 0; cpol = 1'b1; cpha = 1'b0; tx = 16'h00FF; loop = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      n_asrt++; if (g_cs_n !== 1'b0) begin n_fail++; $display("FAIL rst_pre_cs: got %b expected 0", g_cs_n); end
      rst_n = 1'b0;
      #1;
      n_asrt++; if ({g_cs_n, g_ready, g_sclk} !== 3'b110) begin n_fail++; $display("FAIL rst_mid_state: got %b expected 110", {g_cs_n, g_ready, g_sclk}); end
      n_asrt++; if (g_rx !== 16'h0) begin n_fail++; $display("FAIL rst_mid_rx: got %h expected 0", g_rx); end
      n_asrt++; if ({g_done, g_mosi} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_out: got %b expected 00", {g_done, g_mosi}); end
      #3;
      rst_n = 1'b1;
      dones = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (g_done) dones++;
      end
      n_asrt++; if (dones != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d expected 0", dones); end
      n_asrt++; if ({g_ready, g_sclk, g_rx} !== {2'b11, 16'h0}) begin n_fail++; $display("FAIL rst_after: got %b/%h expected 11/0000", {g_ready, g_sclk}, g_rx); end
   endtask

   task automatic test_wide;
      int nd, tg, nl, nt, mg; logic [15:0] seq; logic ok;
      run_xfer(2, 1'b0, 1'b0, 16'hBEEF, 1'b1, 8'h00, nd, tg, nl, nt, mg, seq, ok);
      n_asrt++; if (nd != 34) begin n_fail++; $display("FAIL w_done_edge: got %0d expected 34", nd); end
      n_asrt++; if (tg != 32) begin n_fail++; $display("FAIL w_toggles: got %0d expected 32", tg); end
      n_asrt++; if (mg != 1) begin n_fail++; $display("FAIL w_toggle_gap: got %0d expected 1", mg); end
      n_asrt++; if (g_rx !== 16'hBEEF) begin n_fail++; $display("FAIL w_rx: got %h expected beef", g_rx); end
      n_asrt++; if (seq !== 16'hF77D) begin n_fail++; $display("FAIL w_mosi_seq: got %h expected f77d", seq); end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_lsb_first();
      test_back_to_back();
      test_reset_mid();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
